// File: rtl/rr_mux_arbiter.sv
// 4-way round-robin arbiter with a registered WIDTH-bit output stage (valid/ready on both sides).
// Define RRMUX_LOCK_EN to add in_lock/locked: a requester may hold the grant across several beats.
module rr_mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data_0,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [WIDTH-1:0] in_data_2,
  input  logic [WIDTH-1:0] in_data_3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
`ifdef RRMUX_LOCK_EN
  ,
  input  logic [3:0]       in_lock,
  output logic             locked
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_arr [4];
  logic [WIDTH-1:0] out_data_reg;
  logic [1:0]       out_src_reg;
  logic [1:0]       ptr_reg;
  logic [1:0]       grant;
  logic             locked_reg;
  logic             lock_req;
  logic             found;
  logic             load_en;
  logic             accept;
  logic [3:0]       eligible;

  assign data_arr[0] = in_data_0;
  assign data_arr[1] = in_data_1;
  assign data_arr[2] = in_data_2;
  assign data_arr[3] = in_data_3;

  assign load_en = (state_reg == EMPTY) || out_ready;

  // While locked the owner is always the requester sitting in the output register.
  assign eligible = locked_reg ? (in_valid & (4'b0001 << out_src_reg)) : in_valid;

  // Scan from ptr+3 down to ptr so the lowest rotated position wins.
  always_comb begin
    grant = ptr_reg;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[ptr_reg + 2'(k)]) begin
        grant = ptr_reg + 2'(k);
        found = 1'b1;
      end
    end
  end

  assign accept   = !rst && load_en && found;
  assign in_ready = accept ? (4'b0001 << grant) : 4'b0000;

`ifdef RRMUX_LOCK_EN
  assign lock_req = in_lock[grant];
  assign locked   = locked_reg;
`else
  assign lock_req = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      out_data_reg <= '0;
      out_src_reg  <= 2'd0;
      ptr_reg      <= 2'd0;
      locked_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        out_data_reg <= data_arr[grant];
        out_src_reg  <= grant;
        locked_reg   <= lock_req;
        // A locking beat keeps the pointer so priority resumes where it was after release.
        if (!lock_req) ptr_reg <= grant + 2'd1;
      end
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomised bench for rr_mux_arbiter checked every cycle against a behavioural model,
// plus directed sequences with literal expectations.
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] d [4];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_src;
`ifdef RRMUX_LOCK_EN
  logic [3:0]  in_lock;
  logic        locked;
`endif

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_ptr;
  bit          m_lock;
  int          m_grant;

  logic [31:0] seq [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data_0 (d[0]),
    .in_data_1 (d[1]),
    .in_data_2 (d[2]),
    .in_data_3 (d[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef RRMUX_LOCK_EN
    ,
    .in_lock   (in_lock),
    .locked    (locked)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_src   = 0;
    m_ptr   = 0;
    m_lock  = 1'b0;
  endfunction

  // First requester in rotated order starting at m_ptr; -1 if none may go.
  function automatic int pick();
    for (int k = 0; k < 4; k++) begin
      int r = (m_ptr + k) % 4;
      if (in_valid[r] && (!m_lock || r == m_src)) return r;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic [3:0] exp_ready;
    bit         load;
    #1;
    load      = !m_valid || out_ready;
    m_grant   = pick();
    exp_ready = (!rst && load && m_grant >= 0) ? 4'(1 << m_grant) : 4'b0000;
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_src",   64'(out_src),   64'(m_src));
`ifdef RRMUX_LOCK_EN
    chk("locked",    64'(locked),    64'(m_lock));
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (load) begin
      if (m_grant >= 0) begin
        m_data  = d[m_grant];
        m_src   = m_grant;
        m_valid = 1'b1;
`ifdef RRMUX_LOCK_EN
        m_lock  = in_lock[m_grant];
`else
        m_lock  = 1'b0;
`endif
        if (!m_lock) m_ptr = (m_grant + 1) % 4;
        $display("beat src=%0d data=%08h lock=%0d", m_src, m_data, m_lock);
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 32'hA0 + 32'(i);
`ifdef RRMUX_LOCK_EN
    in_lock   = 4'h0;
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // reset held with all requesters valid
    cycle();
    cycle();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;

    // back-to-back round robin
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_seq", 64'(out_data), 64'(seq[i]));
    end

    // backpressure while holding A1
    cycle();
    chk("bp_load", 64'(out_data), 64'h0A1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_data", 64'(out_data), 64'h0A1);
      chk("bp_hold_src",  64'(out_src),  64'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release", 64'(out_data), 64'h0A2);

    // ptr=3, only requester 1 valid; then 0 and 2 with ptr=2
    in_valid = 4'b0010;
    cycle();
    chk("wrap_src1", 64'(out_src), 64'd1);
    in_valid = 4'b0101;
    cycle();
    chk("skip_src2", 64'(out_src), 64'd2);

    // reset mid-transfer with ptr=2
    in_valid = 4'b0010;
    cycle();
    rst      = 1'b1;
    in_valid = 4'hF;
    cycle();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    cycle();
    chk("midrst_src0", 64'(out_src), 64'd0);

`ifdef RRMUX_LOCK_EN
    in_valid = 4'b0010;
    cycle();
    in_valid = 4'hF;
    in_lock  = 4'b0100;
    cycle();
    chk("lock_src_a", 64'(out_src), 64'd2);
    chk("lock_on_a",  64'(locked),  64'd1);
    cycle();
    chk("lock_src_b", 64'(out_src), 64'd2);
    chk("lock_on_b",  64'(locked),  64'd1);
    in_lock = 4'b0000;
    cycle();
    chk("lock_src_c", 64'(out_src), 64'd2);
    chk("lock_off_c", 64'(locked),  64'd0);
    cycle();
    chk("lock_next3", 64'(out_src), 64'd3);
`endif

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d[i] = $urandom;
`ifdef RRMUX_LOCK_EN
      in_lock   = 4'($urandom & $urandom);
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
